// File: rtl/cpu_decode_q_if.sv
// Fetch-side and execute-side handshake bundle of the cpu_decode_q decode queue.
// illegal_o exists only when MOXIE_DECODE_ILLEGAL_TRAP_EN is defined.
interface cpu_decode_q_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 6
);
    logic              valid_i;
    logic              ready_o;
    logic [15:0]       opcode_i;
    logic [DATA_W-1:0] operand_i;
    logic              valid_o;
    logic              ready_i;
    logic [OP_W-1:0]   op_o;
    logic [3:0]        riA_o;
    logic [3:0]        riB_o;
    logic              register_write_enable_o;
    logic [3:0]        register_write_index_o;
    logic [DATA_W-1:0] operand_o;
`ifdef MOXIE_DECODE_ILLEGAL_TRAP_EN
    logic              illegal_o;
`endif

    modport slave (
        input  valid_i, opcode_i, operand_i, ready_i,
        output ready_o, valid_o, op_o, riA_o, riB_o,
               register_write_enable_o, register_write_index_o, operand_o
`ifdef MOXIE_DECODE_ILLEGAL_TRAP_EN
             , illegal_o
`endif
    );

    modport master (
        output valid_i, opcode_i, operand_i, ready_i,
        input  ready_o, valid_o, op_o, riA_o, riB_o,
               register_write_enable_o, register_write_index_o, operand_o
`ifdef MOXIE_DECODE_ILLEGAL_TRAP_EN
             , illegal_o
`endif
    );
endinterface

// File: rtl/cpu_decode_q.sv
// Moxie decode stage: decodes each accepted fetch beat and queues up to DEPTH entries for execute.
// Optional MOXIE_DECODE_ILLEGAL_TRAP_EN adds illegal_o and blocks intake after an OP_BAD until flush.
module cpu_decode_q #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned OP_W   = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    cpu_decode_q_if.slave         bus,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Op codes: form-1 ops reuse their opcode byte; the unassigned gaps hold the rest.
    localparam logic [5:0] OP_BAD = 6'h0F;
    localparam logic [5:0] OP_INC = 6'h10;
    localparam logic [5:0] OP_DEC = 6'h11;
    localparam logic [5:0] OP_GSR = 6'h12;
    localparam logic [5:0] OP_SSR = 6'h13;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [3:0]        ria;
        logic [3:0]        rib;
        logic              wren;
        logic [DATA_W-1:0] imm;
    } entry_t;

    function automatic logic [5:0] branch_op(input logic [3:0] cond);
        case (cond)
            4'h0:    branch_op = 6'h14;  // BEQ
            4'h1:    branch_op = 6'h15;  // BNE
            4'h2:    branch_op = 6'h16;  // BLT
            4'h3:    branch_op = 6'h17;  // BGT
            4'h4:    branch_op = 6'h18;  // BLTU
            4'h5:    branch_op = 6'h3A;  // BGTU
            4'h6:    branch_op = 6'h3B;  // BGE
            4'h7:    branch_op = 6'h3C;  // BLE
            4'h8:    branch_op = 6'h3D;  // BGEU
            4'h9:    branch_op = 6'h3E;  // BLEU
            default: branch_op = OP_BAD;
        endcase
    endfunction

    function automatic entry_t decode(input logic [15:0] opc, input logic [DATA_W-1:0] opd);
        entry_t     e;
        logic [5:0] op6;
        op6    = OP_BAD;
        e.ria  = opc[7:4];
        e.rib  = opc[3:0];
        e.wren = 1'b0;
        e.imm  = '0;
        if (!opc[15]) begin
            if (!(opc[14] || (opc[13:8] >= 6'h3A) || ((opc[13:8] >= 6'h0F) && (opc[13:8] <= 6'h18)))) begin
                op6 = opc[13:8];
                case (opc[13:8])
                    6'h01, 6'h02, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h1B, 6'h1C, 6'h1D, 6'h20,
                    6'h21, 6'h22, 6'h26, 6'h27, 6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2D,
                    6'h2E, 6'h2F, 6'h31, 6'h32, 6'h33, 6'h34, 6'h36, 6'h38: e.wren = 1'b1;
                    default: ;
                endcase
                case (opc[13:8])
                    6'h01, 6'h03, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h1A, 6'h1B, 6'h1D, 6'h1F,
                    6'h20, 6'h22, 6'h24, 6'h36, 6'h37, 6'h38, 6'h39: e.imm = opd;
                    default: ;
                endcase
            end
        end else if (!opc[14]) begin
            // Form 2: INC/DEC immediate or GSR/SSR special-register number.
            e.ria = opc[11:8];
            e.imm = {{(DATA_W-8){1'b0}}, opc[7:0]};
            case (opc[13:12])
                2'b00:   begin op6 = OP_INC; e.wren = 1'b1; end
                2'b01:   begin op6 = OP_DEC; e.wren = 1'b1; end
                2'b10:   begin op6 = OP_GSR; e.wren = 1'b1; end
                default: op6 = OP_SSR;
            endcase
        end else begin
            // Form 3: halfword branch displacement, sign-extended to a byte offset.
            e.ria = opc[11:8];
            op6   = branch_op(opc[13:10]);
            if (op6 != OP_BAD) e.imm = {{(DATA_W-11){opc[9]}}, opc[9:0], 1'b0};
        end
        e.op = OP_W'(op6);
        return e;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    entry_t           mem_q [DEPTH];
    entry_t           head_q, head_d, new_e;
    logic [CNT_W-1:0] count_q, count_d, cnt_after_pop;
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic             valid_q, valid_d;
    logic             push, pop, ready_c;
`ifdef MOXIE_DECODE_ILLEGAL_TRAP_EN
    logic             trap_q, trap_d, illegal_q, illegal_d;
`endif

    // Queue control and next head selection; flush wins over push and pop.
    always_comb begin
        new_e         = decode(bus.opcode_i, bus.operand_i);
        pop           = valid_q & bus.ready_i;
        ready_c       = (count_q < CNT_W'(DEPTH)) | pop;
`ifdef MOXIE_DECODE_ILLEGAL_TRAP_EN
        ready_c       = ready_c & ~trap_q;
`endif
        push          = bus.valid_i & ready_c & ~flush_i;
        cnt_after_pop = count_q - CNT_W'(pop);
        count_d       = count_q;
        rd_d          = rd_q;
        wr_d          = wr_q;
        valid_d       = valid_q;
        head_d        = head_q;
`ifdef MOXIE_DECODE_ILLEGAL_TRAP_EN
        trap_d        = trap_q;
        illegal_d     = illegal_q;
`endif
        if (flush_i) begin
            count_d = '0;
            rd_d    = '0;
            wr_d    = '0;
            valid_d = 1'b0;
`ifdef MOXIE_DECODE_ILLEGAL_TRAP_EN
            trap_d  = 1'b0;
`endif
        end else begin
            count_d = cnt_after_pop + CNT_W'(push);
            if (pop)  rd_d = ptr_inc(rd_q);
            if (push) wr_d = ptr_inc(wr_q);
            valid_d = (count_d != '0);
            if (valid_d) head_d = (cnt_after_pop == '0) ? new_e : mem_q[rd_d];
`ifdef MOXIE_DECODE_ILLEGAL_TRAP_EN
            if (valid_d) illegal_d = (head_d.op == OP_W'(OP_BAD));
            if (push && (new_e.op == OP_W'(OP_BAD))) trap_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q   <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            valid_q   <= 1'b0;
            head_q    <= '0;
`ifdef MOXIE_DECODE_ILLEGAL_TRAP_EN
            trap_q    <= 1'b0;
            illegal_q <= 1'b0;
`endif
        end else begin
            count_q   <= count_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            valid_q   <= valid_d;
            head_q    <= head_d;
`ifdef MOXIE_DECODE_ILLEGAL_TRAP_EN
            trap_q    <= trap_d;
            illegal_q <= illegal_d;
`endif
        end
    end

    // Entry storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= new_e;
    end

    assign bus.ready_o                 = ready_c;
    assign bus.valid_o                 = valid_q;
    assign bus.op_o                    = head_q.op;
    assign bus.riA_o                   = head_q.ria;
    assign bus.riB_o                   = head_q.rib;
    assign bus.register_write_enable_o = head_q.wren;
    assign bus.register_write_index_o  = head_q.ria;
    assign bus.operand_o               = head_q.imm;
`ifdef MOXIE_DECODE_ILLEGAL_TRAP_EN
    assign bus.illegal_o               = illegal_q;
`endif
    assign count_o                     = count_q;
endmodule
